sequence_generator: RTL

Serial pattern transmitter; the stimulus-side counterpart of the 4-bit sequence detector. It captures a PAT_W-bit pattern on a start request and shifts it out MSB-first, one bit per clk. It can repeat the pattern with programmable idle gaps between repetitions. It also drives a framing marker so a bench or a downstream detector can check detection alignment in hardware instead of through hand-written bit sequences.

---
 rtl/sequence_generator_pkg.sv | 15 +
 rtl/seq_shift_reg.sv | 29 ++
 rtl/sequence_generator.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sequence_generator_pkg.sv
// Shared types and width defaults for the serial
// pattern transmitter.
package sequence_generator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 4;
  localparam int GAP_W_DEF = 4;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load MSB-first register; nxt_o is the bit
// that follows the one currently on the serial line.
module seq_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         nxt_o
);

  logic [W-1:0] q_q;

  // Load wins over shift; shifting rotates so no bit is lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= data_i;
    end else if (shift_i) begin
      q_q <= {q_q[W-2:0], q_q[W-1]};
    end
  end

  assign nxt_o = q_q[W-2];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a captured pattern
// MSB-first with optional repeats and idle gaps.
module sequence_generator
  import sequence_generator_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             idle_bit,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0] LAST_IDX = BW'(PAT_W - 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [GAP_W-1:0] glen_q, glen_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sr_load;
  logic             sr_shift;
  logic [PAT_W-1:0] sr_data;
  logic             sr_nxt;
  logic [BW-1:0]    bit_inc;

  assign bit_inc = bit_q + BW'(1);

  seq_shift_reg #(
    .W(PAT_W)
  ) u_sr (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (sr_load),
    .shift_i(sr_shift),
    .data_i (sr_data),
    .nxt_o  (sr_nxt)
  );

  // Next state, counters and registered-output values.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    rep_d    = rep_q;
    gcnt_d   = gcnt_q;
    glen_d   = glen_q;
    pat_d    = pat_q;
    x_d      = 1'b0;
    xv_d     = 1'b0;
    last_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_data  = pat_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = SEND;
          pat_d   = pattern;
          rep_d   = repeat_cnt;
          glen_d  = gap_len;
          bit_d   = '0;
          gcnt_d  = '0;
          sr_load = 1'b1;
          sr_data = pattern;
          x_d     = pattern[PAT_W-1];
          xv_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
          bit_d   = '0;
          rep_d   = '0;
          gcnt_d  = '0;
        end else if (bit_q != LAST_IDX) begin
          bit_d    = bit_inc;
          sr_shift = 1'b1;
          x_d      = sr_nxt;
          xv_d     = 1'b1;
          busy_d   = 1'b1;
          last_d   = (bit_inc == LAST_IDX);
        end else if (rep_q != '0) begin
          rep_d   = rep_q - CNT_W'(1);
          bit_d   = '0;
          sr_load = 1'b1;
          busy_d  = 1'b1;
          if (glen_q != '0) begin
            state_d = GAP;
            gcnt_d  = GAP_W'(1);
            x_d     = idle_bit;
          end else begin
            x_d  = pat_q[PAT_W-1];
            xv_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
          bit_d   = '0;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
          bit_d   = '0;
          rep_d   = '0;
          gcnt_d  = '0;
        end else if (gcnt_q == glen_q) begin
          state_d = SEND;
          bit_d   = '0;
          gcnt_d  = '0;
          x_d     = pat_q[PAT_W-1];
          xv_d    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          gcnt_d = gcnt_q + GAP_W'(1);
          x_d    = idle_bit;
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      rep_q   <= '0;
      gcnt_q  <= '0;
      glen_q  <= '0;
      pat_q   <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      gcnt_q  <= gcnt_d;
      glen_q  <= glen_d;
      pat_q   <= pat_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x       = x_q;
  assign x_valid = xv_q;
  assign last    = last_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
